// File: rtl/mem_rw_model_pkg.sv
// Shared types for the single-port memory model: FSM states, error-inject codes,
// and the decoder that folds the reserved inject code onto "clear".
package mem_model_pkg;

  localparam int MAX_LATENCY = 30;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_state_e;

  typedef enum logic [1:0] {
    INJ_NONE = 2'd0,
    INJ_SERR = 2'd1,
    INJ_DERR = 2'd2
  } inj_e;

  // Code 3 is reserved and behaves exactly like a clear.
  function automatic inj_e inj_decode(input logic [1:0] code);
    case (code)
      2'd1:    return INJ_SERR;
      2'd2:    return INJ_DERR;
      default: return INJ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_rw_model_if.sv
// Request/response bundle between a memory driver (master) and the memory model (slave).
interface mem_rw_model_if
  import mem_model_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) ();

  // Handshake: read/write are single-cycle strobes sampled at posedge with no
  // backpressure; each strobe is either accepted that edge or dropped and latched
  // into proto_err. read_vld is a one-cycle strobe qualifying dout/read_serr/read_derr.
  logic          read;
  logic          write;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          read_vld;
  logic          read_serr;
  logic          read_derr;
  logic [DW-1:0] dout;
  logic          ready;
  logic          refr;
  logic          inj_en;
  logic [AW-1:0] inj_addr;
  logic [1:0]    inj_type;
  logic          proto_err;
  mem_state_e    dbg_state;

  modport master (
    output read, write, addr, din, inj_en, inj_addr, inj_type,
    input  read_vld, read_serr, read_derr, dout, ready, refr, proto_err, dbg_state
  );

  modport slave (
    input  read, write, addr, din, inj_en, inj_addr, inj_type,
    output read_vld, read_serr, read_derr, dout, ready, refr, proto_err, dbg_state
  );

endinterface

// File: rtl/mem_rw_model_lat_pipe.sv
// Fixed-depth shift register carrying read responses from the acceptance edge to
// the output; a synchronous flush drops everything in flight.
module mem_lat_pipe #(
  parameter int W       = 35,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_d
);

  logic [W-1:0] r_stage [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < LATENCY; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_d = r_stage[LATENCY-1];

endmodule

// File: rtl/mem_rw_model.sv
// Cycle-accurate single-port memory model: post-reset clearing sweep, periodic
// refresh windows, per-word error injection and a fixed-latency read return path.
module mem_rw_model
  import mem_model_pkg::*;
#(
  parameter int AW          = 8,
  parameter int DW          = 32,
  parameter int WORDS       = 256,
  parameter int LATENCY     = 1,
  parameter int REFR_PERIOD = 64
) (
  input  logic           clk,
  input  logic           rst,
  mem_rw_model_if.slave  bus
);

  localparam int            CW       = (REFR_PERIOD > 1) ? $clog2(REFR_PERIOD) : 1;
  localparam bit            REFR_EN  = (REFR_PERIOD > 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((REFR_PERIOD > 0) ? REFR_PERIOD - 1 : 0);
  localparam logic [AW-1:0] PTR_LAST = AW'(WORDS - 1);
  localparam int            PW       = DW + 3;

  logic [DW-1:0] r_mem  [WORDS];
  inj_e          r_flag [WORDS];

  mem_state_e    r_state;
  logic [AW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_refr;
  logic          r_proto_err;

  logic          w_req;
  logic          w_in_range;
  logic          w_inj_in_range;
  logic          w_legal;
  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [AW-1:0] w_rd_idx;
  logic [AW-1:0] w_inj_idx;
  logic [DW-1:0] w_rd_data;
  logic          w_rd_serr;
  logic          w_rd_derr;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_pipe_in;
  logic [PW-1:0] w_pipe_out;

  assign w_req          = bus.read | bus.write;
  assign w_in_range     = ({1'b0, bus.addr} < (AW+1)'(WORDS));
  assign w_inj_in_range = ({1'b0, bus.inj_addr} < (AW+1)'(WORDS));
  assign w_legal        = r_ready & ~r_refr & ~(bus.read & bus.write) & w_in_range;
  assign w_rd_acc       = bus.read & w_legal;
  assign w_wr_acc       = bus.write & w_legal;
  assign w_rd_idx       = w_in_range ? bus.addr : '0;
  assign w_inj_idx      = w_inj_in_range ? bus.inj_addr : '0;
  assign w_cnt_nxt      = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);

  // Response is formed from the pre-edge array contents, so an inject landing on
  // the same word in the same cycle is not yet visible to this read.
  always_comb begin
    w_rd_data = r_mem[w_rd_idx];
    w_rd_serr = 1'b0;
    w_rd_derr = 1'b0;
    case (r_flag[w_rd_idx])
      INJ_SERR: w_rd_serr = 1'b1;
      INJ_DERR: begin
        w_rd_derr = 1'b1;
        w_rd_data = w_rd_data ^ DW'(3);
      end
      default: ;
    endcase
    w_pipe_in = w_rd_acc ? {1'b1, w_rd_serr, w_rd_derr, w_rd_data} : '0;
  end

  // Storage: the write is applied after the inject so a same-word write wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) begin
        r_mem[r_ptr]  <= '0;
        r_flag[r_ptr] <= INJ_NONE;
      end else begin
        if (bus.inj_en && w_inj_in_range) r_flag[w_inj_idx] <= inj_decode(bus.inj_type);
        if (w_wr_acc) begin
          r_mem[bus.addr]  <= bus.din;
          r_flag[bus.addr] <= INJ_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_refr      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_req && !w_legal) r_proto_err <= 1'b1;
      case (r_state)
        INIT: begin
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == PTR_LAST) begin
            r_state <= RUN;
            r_ready <= 1'b1;
            r_cnt   <= '0;
            r_refr  <= REFR_EN && (CNT_LAST == '0);
          end
        end
        RUN: begin
          r_cnt  <= w_cnt_nxt;
          r_refr <= REFR_EN && (w_cnt_nxt == CNT_LAST);
        end
        default: r_state <= INIT;
      endcase
    end
  end

  mem_lat_pipe #(
    .W       (PW),
    .LATENCY (LATENCY)
  ) u_lat_pipe (
    .clk (clk),
    .rst (rst),
    .i_d (w_pipe_in),
    .o_d (w_pipe_out)
  );

  assign bus.read_vld  = w_pipe_out[DW+2];
  assign bus.read_serr = w_pipe_out[DW+1];
  assign bus.read_derr = w_pipe_out[DW];
  assign bus.dout      = w_pipe_out[DW-1:0];
  assign bus.ready     = r_ready;
  assign bus.refr      = r_refr;
  assign bus.proto_err = r_proto_err;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_mem_rw_model.sv
// Bench for mem_rw_model: directed scenarios with literal expectations plus a random
// phase, all cross-checked every cycle against a word-level reference model.
module tb_mem_rw_model;
  import mem_model_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int WORDS = 200;
  localparam int LAT   = 3;
  localparam int RP    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rw_model_if #(.AW(AW), .DW(DW)) bus ();

  mem_rw_model #(
    .AW(AW), .DW(DW), .WORDS(WORDS), .LATENCY(LAT), .REFR_PERIOD(RP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: whole-array view, reset clears everything at once, reads are
  // queued with the cycle they are due on.
  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } rd_t;

  rd_t           exp_q[$];
  logic [DW-1:0] m_mem  [WORDS];
  logic [1:0]    m_flag [WORDS];
  bit            m_started = 0;
  bit            m_ready   = 0;
  bit            m_refr    = 0;
  bit            m_proto   = 0;
  int            m_cyc     = 0;
  int            m_init_n  = 0;
  int            m_age     = 0;
  logic          m_vld     = 1'b0;
  logic [DW-1:0] m_d       = '0;
  logic          m_s       = 1'b0;
  logic          m_e       = 1'b0;

  initial begin : model
    bit  legal;
    int  a;
    rd_t r;
    forever begin
      @(posedge clk);
      m_cyc++;
      if (rst) begin
        m_started = 1;
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) begin
          m_mem[i]  = '0;
          m_flag[i] = 2'd0;
        end
        m_ready = 0; m_refr = 0; m_proto = 0; m_init_n = 0; m_age = 0;
      end else if (m_started) begin
        a = int'(bus.addr);
        legal = m_ready && !m_refr && !(bus.read && bus.write) && (a < WORDS);
        if ((bus.read || bus.write) && !legal) m_proto = 1;
        if (bus.read && legal) begin
          r.due = m_cyc + LAT - 1;
          r.d   = m_mem[a];
          r.s   = (m_flag[a] == 2'd1);
          r.e   = (m_flag[a] == 2'd2);
          if (r.e) r.d = r.d ^ 32'h3;
          exp_q.push_back(r);
        end
        if (bus.inj_en && m_ready && int'(bus.inj_addr) < WORDS)
          m_flag[int'(bus.inj_addr)] = (bus.inj_type == 2'd1 || bus.inj_type == 2'd2) ? bus.inj_type : 2'd0;
        if (bus.write && legal) begin
          m_mem[a]  = bus.din;
          m_flag[a] = 2'd0;
        end
        if (!m_ready) begin
          m_init_n++;
          if (m_init_n == WORDS) begin
            m_ready = 1;
            m_age   = 0;
          end
        end else begin
          m_age++;
        end
        m_refr = m_ready && ((m_age % RP) == RP - 1);
      end
      m_vld = 1'b0; m_d = '0; m_s = 1'b0; m_e = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == m_cyc) begin
        r = exp_q.pop_front();
        m_vld = 1'b1; m_d = r.d; m_s = r.s; m_e = r.e;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_started) begin
        check("read_vld",  64'(bus.read_vld),  64'(m_vld));
        check("dout",      64'(bus.dout),      64'(m_d));
        check("read_serr", 64'(bus.read_serr), 64'(m_s));
        check("read_derr", 64'(bus.read_derr), 64'(m_e));
        check("ready",     64'(bus.ready),     64'(m_ready));
        check("refr",      64'(bus.refr),      64'(m_refr));
        check("proto_err", 64'(bus.proto_err), 64'(m_proto));
        check("dbg_state", 64'(bus.dbg_state), 64'(m_ready ? RUN : INIT));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Driver tasks: called at a negedge, return at a later negedge.
  task automatic idle();
    bus.read = 1'b0; bus.write = 1'b0; bus.inj_en = 1'b0;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic ie,
                       input logic [AW-1:0] ia, input logic [1:0] it);
    bus.read = rd; bus.write = wr; bus.addr = a; bus.din = d;
    bus.inj_en = ie; bus.inj_addr = ia; bus.inj_type = it;
    @(negedge clk);
    idle();
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0, '0, 2'd0);
  endtask

  task automatic inj(input logic [AW-1:0] a, input logic [1:0] t);
    drive(1'b0, 1'b0, '0, '0, 1'b1, a, t);
  endtask

  task automatic rd_lat(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d,
                        output logic s, output logic e);
    drive(1'b1, 1'b0, a, '0, 1'b0, '0, 2'd0);
    lat = 1;
    while (!bus.read_vld && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    d = bus.dout; s = bus.read_serr; e = bus.read_derr;
  endtask

  // Lands on the first cycle after a refresh window: RP-1 refresh-free cycles follow.
  task automatic sync_refr();
    int n = 0;
    while (!m_refr && n < 2 * RP) begin
      @(negedge clk);
      n++;
    end
    if (!m_refr) check("sync_refr_timeout", 64'(m_refr), 64'(1));
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!m_ready && n < WORDS + 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_after_init", 64'(bus.ready), 64'(1));
  endtask

  task automatic count_vld(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.read_vld) c++;
    end
  endtask

  initial begin : main
    int            lat;
    int            c;
    int            n;
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    logic          rd;
    logic          wr;

    bus.addr = '0; bus.din = '0; bus.inj_addr = '0; bus.inj_type = 2'd0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Init sweep length, then a read of a freshly cleared word.
    repeat (WORDS - 1) @(negedge clk);
    check("t1_ready_low", 64'(bus.ready), 64'(0));
    @(negedge clk);
    check("t1_ready_high", 64'(bus.ready), 64'(1));
    rd_lat(8'd5, lat, d, s, e);
    check("t1_latency", 64'(lat), 64'(3));
    check("t1_dout", 64'(d), 64'h0);

    // Write then read next cycle.
    sync_refr();
    wr_word(8'h10, 32'hDEADBEEF);
    rd_lat(8'h10, lat, d, s, e);
    check("t2_latency", 64'(lat), 64'(3));
    check("t2_dout", 64'(d), 64'hDEADBEEF);
    check("t2_serr", 64'(s), 64'(0));
    check("t2_derr", 64'(e), 64'(0));

    // Single, double, and cleared-by-write error flags.
    sync_refr();
    inj(8'h10, 2'd1);
    rd_lat(8'h10, lat, d, s, e);
    check("t3_serr_dout", 64'(d), 64'hDEADBEEF);
    check("t3_serr_flag", 64'(s), 64'(1));
    check("t3_serr_noderr", 64'(e), 64'(0));
    sync_refr();
    inj(8'h10, 2'd2);
    rd_lat(8'h10, lat, d, s, e);
    check("t3_derr_dout", 64'(d), 64'hDEADBEEC);
    check("t3_derr_flag", 64'(e), 64'(1));
    check("t3_derr_noserr", 64'(s), 64'(0));
    sync_refr();
    wr_word(8'h10, 32'hDEADBEEF);
    rd_lat(8'h10, lat, d, s, e);
    check("t3_clear_serr", 64'(s), 64'(0));
    check("t3_clear_derr", 64'(e), 64'(0));

    // Inject and read on the same word in the same cycle: read sees the old flag.
    sync_refr();
    wr_word(8'h20, 32'h12345678);
    drive(1'b1, 1'b0, 8'h20, '0, 1'b1, 8'h20, 2'd1);
    repeat (LAT - 1) @(negedge clk);
    check("t3_samecyc_vld", 64'(bus.read_vld), 64'(1));
    check("t3_samecyc_serr", 64'(bus.read_serr), 64'(0));
    rd_lat(8'h20, lat, d, s, e);
    check("t3_after_inj_serr", 64'(s), 64'(1));

    // Write beats a same-cycle inject; reserved code 3 clears.
    sync_refr();
    drive(1'b0, 1'b1, 8'h30, 32'hCAFEF00D, 1'b1, 8'h30, 2'd2);
    rd_lat(8'h30, lat, d, s, e);
    check("t3_wr_wins_dout", 64'(d), 64'hCAFEF00D);
    check("t3_wr_wins_derr", 64'(e), 64'(0));
    sync_refr();
    inj(8'h30, 2'd2);
    inj(8'h30, 2'd3);
    rd_lat(8'h30, lat, d, s, e);
    check("t3_code3_derr", 64'(e), 64'(0));

    // Illegal requests.
    check("t4_proto_clean", 64'(bus.proto_err), 64'(0));
    sync_refr();
    drive(1'b1, 1'b1, 8'h10, 32'h1, 1'b0, '0, 2'd0);
    count_vld(LAT + 1, c);
    check("t4_rw_no_vld", 64'(c), 64'(0));
    check("t4_rw_proto", 64'(bus.proto_err), 64'(1));
    do_reset();
    check("t4_proto_reset", 64'(bus.proto_err), 64'(0));
    drive(1'b1, 1'b0, 8'h5, '0, 1'b0, '0, 2'd0);
    check("t4_notready_proto", 64'(bus.proto_err), 64'(1));
    count_vld(LAT + 1, c);
    check("t4_notready_no_vld", 64'(c), 64'(0));
    wait_ready();
    do_reset();
    wait_ready();
    sync_refr();
    drive(1'b1, 1'b0, AW'(WORDS + 3), '0, 1'b0, '0, 2'd0);
    check("t4_range_proto", 64'(bus.proto_err), 64'(1));
    do_reset();
    wait_ready();

    // Refresh period and the edges around a refresh window.
    n = 0;
    while (!bus.refr && n < 2 * RP) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.refr && n < 3 * RP);
    check("t5_refr_period", 64'(n), 64'(8));
    repeat (RP - 1) @(negedge clk);
    check("t5_pre_refr", 64'(bus.refr), 64'(0));
    bus.read = 1'b1; bus.addr = 8'h7;
    @(negedge clk);
    check("t5_in_refr", 64'(bus.refr), 64'(1));
    bus.addr = 8'h8;
    @(negedge clk);
    idle();
    count_vld(6, c);
    check("t5_one_return", 64'(c), 64'(1));
    check("t5_refr_proto", 64'(bus.proto_err), 64'(1));

    // Reset with reads in flight: nothing returns, sweep restarts.
    do_reset();
    wait_ready();
    bus.read = 1'b1; bus.addr = 8'h1;
    @(negedge clk);
    bus.addr = 8'h2;
    @(negedge clk);
    bus.addr = 8'h3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    n = 0; c = 0;
    while (!bus.ready && n < WORDS + 20) begin
      @(negedge clk);
      n++;
      if (bus.read_vld) c++;
    end
    check("t6_init_len", 64'(n), 64'(WORDS));
    check("t6_no_vld", 64'(c), 64'(0));
    check("t6_proto", 64'(bus.proto_err), 64'(0));

    // Random traffic on a small hot address set, with rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 799) == 0);
      rd  = ($urandom_range(0, 99) < 45);
      wr  = ($urandom_range(0, 99) < 30);
      if (rd && wr && $urandom_range(0, 9) != 0) wr = 1'b0;
      if (m_refr && $urandom_range(0, 9) != 0) begin
        rd = 1'b0;
        wr = 1'b0;
      end
      bus.read     = rd;
      bus.write    = wr;
      bus.addr     = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
      bus.din      = $urandom;
      bus.inj_en   = ($urandom_range(0, 9) == 0);
      bus.inj_addr = AW'($urandom_range(0, 15));
      bus.inj_type = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    repeat (LAT + 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
